// File: rtl/gps_ca_code_gen.sv
// GPS L1 C/A Gold code generator. One chip is produced per chip-rate strobe for the
// satellite selected by the two G2 phase-selector taps latched at start.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   start      pulse: latch taps, restart the code at chip 0 (illegal taps -> tap_err, IDLE)
//   stop       pulse: return to IDLE (wins over start and chip_en)
//   chip_en    chip-rate strobe from the chipping NCO, ignored in IDLE
//   tap_a/b    G2 output taps, legal 1..10 and distinct
//   chip_out   registered code chip
//   chip_valid one-cycle pulse, one cycle after each accepted chip_en
//   chip_idx   index of the chip held in chip_out
//   epoch      pulse with chip_valid for the last chip of the code period
//   busy       high while running
//   tap_err    sticky: the most recent start carried illegal taps
//
// Optional build macro NAV_DATA_XOR_EN adds nav_bit/nav_req and the NAV_EPOCHS
// parameter: the code is XORed with a nav bit re-latched every NAV_EPOCHS epochs.
module gps_ca_code_gen #(
  parameter int unsigned CODE_LEN = 1023
`ifdef NAV_DATA_XOR_EN
  ,
  parameter int unsigned NAV_EPOCHS = 20
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       chip_en,
  input  logic [3:0] tap_a,
  input  logic [3:0] tap_b,
`ifdef NAV_DATA_XOR_EN
  input  logic       nav_bit,
  output logic       nav_req,
`endif
  output logic       chip_out,
  output logic       chip_valid,
  output logic [9:0] chip_idx,
  output logic       epoch,
  output logic       busy,
  output logic       tap_err
);

  localparam logic StIdle = 1'b0;
  localparam logic StRun  = 1'b1;

  localparam logic [9:0] LastIdx = 10'(CODE_LEN - 1);

  // Stages numbered 1..10 to match the polynomial description; stage 1 takes feedback.
  logic [10:1] g1_q, g1_d;
  logic [10:1] g2_q, g2_d;
  logic [9:0]  idx_q, idx_d;
  logic [3:0]  tap_a_q, tap_a_d;
  logic [3:0]  tap_b_q, tap_b_d;
  logic        state_q, state_d;
  logic        chip_out_q, chip_out_d;
  logic        chip_valid_q, chip_valid_d;
  logic [9:0]  chip_idx_q, chip_idx_d;
  logic        epoch_q, epoch_d;
  logic        tap_err_q, tap_err_d;

  logic        taps_legal;
  logic        code_chip;
  logic        last_chip;
  logic        fire;

  function automatic logic g2_sel(input logic [10:1] g, input logic [3:0] t);
    logic s;
    case (t)
      4'd1:    s = g[1];
      4'd2:    s = g[2];
      4'd3:    s = g[3];
      4'd4:    s = g[4];
      4'd5:    s = g[5];
      4'd6:    s = g[6];
      4'd7:    s = g[7];
      4'd8:    s = g[8];
      4'd9:    s = g[9];
      4'd10:   s = g[10];
      default: s = 1'b0;
    endcase
    return s;
  endfunction

  assign taps_legal = (tap_a >= 4'd1) && (tap_a <= 4'd10) &&
                      (tap_b >= 4'd1) && (tap_b <= 4'd10) && (tap_a != tap_b);
  assign code_chip  = g1_q[10] ^ g2_sel(g2_q, tap_a_q) ^ g2_sel(g2_q, tap_b_q);
  assign last_chip  = (idx_q == LastIdx);
  // A strobe only counts when no start/stop competes with it in the same cycle.
  assign fire       = (state_q == StRun) && chip_en && !start && !stop;

`ifdef NAV_DATA_XOR_EN
  localparam int unsigned NavW = (NAV_EPOCHS > 1) ? $clog2(NAV_EPOCHS) : 1;
  localparam logic [NavW-1:0] NavLast = NavW'(NAV_EPOCHS - 1);

  logic            nav_q, nav_d;
  logic [NavW-1:0] nav_cnt_q, nav_cnt_d;
  logic            nav_pend_q, nav_pend_d; // new nav bit takes effect; flag the next chip 0
  logic            nav_req_q, nav_req_d;
  logic            out_chip;

  assign out_chip = code_chip ^ nav_q;
  assign nav_req  = nav_req_q;

  always_comb begin
    nav_d      = nav_q;
    nav_cnt_d  = nav_cnt_q;
    nav_pend_d = nav_pend_q;
    nav_req_d  = 1'b0;
    if (stop) begin
      nav_d = nav_q;
    end else if (start) begin
      if (taps_legal) begin
        nav_d      = nav_bit;
        nav_cnt_d  = '0;
        nav_pend_d = 1'b0;
      end
    end else if (fire) begin
      if (idx_q == 10'd0) begin
        nav_req_d  = nav_pend_q;
        nav_pend_d = 1'b0;
      end
      if (last_chip) begin
        if (nav_cnt_q == NavLast) begin
          nav_cnt_d  = '0;
          nav_d      = nav_bit;
          nav_pend_d = 1'b1;
        end else begin
          nav_cnt_d = nav_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nav_q      <= 1'b0;
      nav_cnt_q  <= '0;
      nav_pend_q <= 1'b0;
      nav_req_q  <= 1'b0;
    end else begin
      nav_q      <= nav_d;
      nav_cnt_q  <= nav_cnt_d;
      nav_pend_q <= nav_pend_d;
      nav_req_q  <= nav_req_d;
    end
  end
`else
  logic out_chip;
  assign out_chip = code_chip;
`endif

  always_comb begin
    g1_d         = g1_q;
    g2_d         = g2_q;
    idx_d        = idx_q;
    tap_a_d      = tap_a_q;
    tap_b_d      = tap_b_q;
    state_d      = state_q;
    chip_out_d   = chip_out_q;
    chip_valid_d = 1'b0;
    chip_idx_d   = chip_idx_q;
    epoch_d      = 1'b0;
    tap_err_d    = tap_err_q;

    if (stop) begin
      state_d = StIdle;
    end else if (start) begin
      if (taps_legal) begin
        tap_a_d   = tap_a;
        tap_b_d   = tap_b;
        g1_d      = '1;
        g2_d      = '1;
        idx_d     = '0;
        tap_err_d = 1'b0;
        state_d   = StRun;
      end else begin
        tap_err_d = 1'b1;
        state_d   = StIdle;
      end
    end else if (fire) begin
      chip_out_d   = out_chip;
      chip_idx_d   = idx_q;
      chip_valid_d = 1'b1;
      epoch_d      = last_chip;
      if (last_chip) begin
        // Reload keeps shortened codes (CODE_LEN < 1023) aligned to the epoch.
        idx_d = '0;
        g1_d  = '1;
        g2_d  = '1;
      end else begin
        idx_d = idx_q + 10'd1;
        g1_d  = {g1_q[9:1], g1_q[3] ^ g1_q[10]};
        g2_d  = {g2_q[9:1], g2_q[2] ^ g2_q[3] ^ g2_q[6] ^ g2_q[8] ^ g2_q[9] ^ g2_q[10]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      g1_q         <= '1;
      g2_q         <= '1;
      idx_q        <= '0;
      tap_a_q      <= '0;
      tap_b_q      <= '0;
      state_q      <= StIdle;
      chip_out_q   <= 1'b0;
      chip_valid_q <= 1'b0;
      chip_idx_q   <= '0;
      epoch_q      <= 1'b0;
      tap_err_q    <= 1'b0;
    end else begin
      g1_q         <= g1_d;
      g2_q         <= g2_d;
      idx_q        <= idx_d;
      tap_a_q      <= tap_a_d;
      tap_b_q      <= tap_b_d;
      state_q      <= state_d;
      chip_out_q   <= chip_out_d;
      chip_valid_q <= chip_valid_d;
      chip_idx_q   <= chip_idx_d;
      epoch_q      <= epoch_d;
      tap_err_q    <= tap_err_d;
    end
  end

  assign chip_out   = chip_out_q;
  assign chip_valid = chip_valid_q;
  assign chip_idx   = chip_idx_q;
  assign epoch      = epoch_q;
  assign busy       = (state_q == StRun);
  assign tap_err    = tap_err_q;

endmodule

// File: tb/tb_gps_ca_code_gen.sv
module tb_gps_ca_code_gen;

  logic       clk = 1'b0;
  logic       rst, start, stop, chip_en;
  logic [3:0] tap_a, tap_b;
  logic       chip_out, chip_valid, epoch, busy, tap_err;
  logic [9:0] chip_idx;

  int vectors = 0;
  int miscompares = 0;

  // First ten chips, MSB first: PRN1 octal 1440, PRN2 octal 1620.
  logic [9:0] prn1 = 10'b1100100000;
  logic [9:0] prn2 = 10'b1110010000;

  gps_ca_code_gen #(.CODE_LEN(1023)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .chip_en    (chip_en),
    .tap_a      (tap_a),
    .tap_b      (tap_b),
    .chip_out   (chip_out),
    .chip_valid (chip_valid),
    .chip_idx   (chip_idx),
    .epoch      (epoch),
    .busy       (busy),
    .tap_err    (tap_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, " chip_out"}, 32'(chip_out), 32'd0);
    check({tag, " chip_valid"}, 32'(chip_valid), 32'd0);
    check({tag, " chip_idx"}, 32'(chip_idx), 32'd0);
    check({tag, " epoch"}, 32'(epoch), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " tap_err"}, 32'(tap_err), 32'd0);
  endtask

  task automatic do_start(input logic [3:0] a, input logic [3:0] b);
    tap_a = a;
    tap_b = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int ep_cnt;
    int ones0;
    int ones1;
    int k;

    rst = 1'b1; start = 1'b1; stop = 1'b0; chip_en = 1'b1; tap_a = 4'd2; tap_b = 4'd6;
    #1;

    // Reset dominates start and chip_en.
    repeat (3) tick();
    check_idle_zero("reset");
    rst = 1'b0; start = 1'b0;
    repeat (3) tick();
    check_idle_zero("post-reset idle");

    // PRN1 with chip_en every cycle.
    chip_en = 1'b0;
    do_start(4'd2, 4'd6);
    check("prn1 busy", 32'(busy), 32'd1);
    check("prn1 no valid at start", 32'(chip_valid), 32'd0);
    chip_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("prn1 valid", 32'(chip_valid), 32'd1);
      check("prn1 idx", 32'(chip_idx), 32'(i));
      check("prn1 chip", 32'(chip_out), 32'(prn1[9 - i]));
    end
    chip_en = 1'b0;
    tick();
    check("prn1 valid drops", 32'(chip_valid), 32'd0);

    // PRN2 with a sparse strobe.
    do_start(4'd3, 4'd7);
    for (int i = 0; i < 10; i++) begin
      chip_en = 1'b1;
      tick();
      chip_en = 1'b0;
      check("prn2 valid", 32'(chip_valid), 32'd1);
      check("prn2 idx", 32'(chip_idx), 32'(i));
      check("prn2 chip", 32'(chip_out), 32'(prn2[9 - i]));
      for (int j = 0; j < 3; j++) begin
        tick();
        check("prn2 gap valid", 32'(chip_valid), 32'd0);
      end
    end

    // Two full epochs of PRN1.
    do_start(4'd2, 4'd6);
    chip_en = 1'b1;
    ep_cnt = 0; ones0 = 0; ones1 = 0;
    for (int n = 0; n < 2046; n++) begin
      tick();
      check("epoch run idx", 32'(chip_idx), 32'(n % 1023));
      check("epoch run flag", 32'(epoch), 32'((n % 1023) == 1022));
      if (epoch) ep_cnt++;
      if (n < 1023) ones0 += int'(chip_out);
      else ones1 += int'(chip_out);
      if (n >= 1023 && n < 1033) begin
        k = 9 - (n - 1023);
        check("epoch2 repeat chip", 32'(chip_out), 32'(prn1[k]));
      end
    end
    chip_en = 1'b0;
    check("epoch count", 32'(ep_cnt), 32'd2);
    check("epoch0 ones", 32'(ones0), 32'd512);
    check("epoch1 ones", 32'(ones1), 32'd512);

    // Illegal taps while running drop to IDLE with tap_err.
    do_start(4'd5, 4'd5);
    check("tap 5,5 err", 32'(tap_err), 32'd1);
    check("tap 5,5 busy", 32'(busy), 32'd0);
    do_start(4'd0, 4'd3);
    check("tap 0,3 err", 32'(tap_err), 32'd1);
    check("tap 0,3 busy", 32'(busy), 32'd0);
    do_start(4'd2, 4'd6);
    check("legal clears err", 32'(tap_err), 32'd0);
    check("legal busy", 32'(busy), 32'd1);
    chip_en = 1'b1;
    repeat (5) tick();
    check("pre-stop idx", 32'(chip_idx), 32'd4);
    // stop + start + chip_en in one cycle: stop wins, outputs hold.
    stop = 1'b1; start = 1'b1;
    tick();
    stop = 1'b0; start = 1'b0; chip_en = 1'b0;
    check("stop wins busy", 32'(busy), 32'd0);
    check("stop valid", 32'(chip_valid), 32'd0);
    check("stop idx hold", 32'(chip_idx), 32'd4);
    check("stop chip hold", 32'(chip_out), 32'(prn1[5]));
    chip_en = 1'b1;
    tick();
    check("idle ignores chip_en", 32'(chip_valid), 32'd0);
    chip_en = 1'b0;

    // Mid-run restart at chip 500.
    do_start(4'd2, 4'd6);
    chip_en = 1'b1;
    repeat (501) tick();
    check("chip 500 idx", 32'(chip_idx), 32'd500);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart swallows chip_en", 32'(chip_valid), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("restart idx", 32'(chip_idx), 32'(i));
      check("restart chip", 32'(chip_out), 32'(prn1[9 - i]));
    end
    repeat (291) tick();
    check("chip 300 idx", 32'(chip_idx), 32'd300);
    rst = 1'b1;
    tick();
    rst = 1'b0; chip_en = 1'b0;
    check_idle_zero("mid-run reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
